matrix_frame_sched: RTL and testbench
=====================================

Name: matrix_frame_sched

Overview:
- Double-buffered frame scheduler for the 8x8 bicolour LED matrix scan driver.
- Requesters write individual pixels into a back buffer. The back buffer is swapped into the displayed front buffer only at a frame boundary, so no frame is ever displayed half-updated.
- Sits between the pattern/animation logic and the matrix driver, and drives the driver's 128-bit data input.

Parameters:
- CLR_VAL, 2'b00, colour pair {G,R} written into every pixel by a clear operation.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- row_tick  in  1  one-cycle pulse, clk-synchronous, asserted each time the matrix driver advances one row
- wr_valid  in  1  pixel write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready at a rising edge
- wr_row  in  3  pixel row, 0..7
- wr_col  in  3  pixel column, 0..7
- wr_rg  in  2  [0]=R, [1]=G, active-high
- clear_req  in  1  level request: fill back buffer with CLR_VAL; held until clear_done
- clear_done  out  1  one-cycle pulse when the clear has finished
- commit_req  in  1  level request: swap buffers at the next frame boundary; held until commit_ack
- commit_ack  out  1  one-cycle pulse in the cycle after the swap edge
- scan_row  out  3  row counter tracking the driver
- data  out  128  front buffer, in the driver's format
- busy  out  1  high in every state except IDLE

Behaviour:
- Data mapping: pixel (r,c) R bit is at index (7-r)*16+2*c; the G bit is at that index +1.
- Reset values: both buffers all-zero, front select 0, state IDLE, scan_row 0, data 0, wr_ready 0, clear_done 0, commit_ack 0, busy 0.
- Reset is asynchronous. Reset asserted mid-operation aborts any clear, commit or copy; a pending commit is discarded.
- wr_ready = (state==IDLE) && !rst. It is combinational from the state register.
- scan_row increments (mod 8) on every row_tick in every state. A frame boundary is a row_tick edge with scan_row==7.
- State IDLE:
  - An accepted write updates the 2 addressed back-buffer bits at that edge; no other bit changes.
  - If clear_req=1, go to CLEAR. Clear has priority over commit when both are high; commit is served after clear_done.
  - Else if commit_req=1, go to PEND.
  - A write accepted in the same cycle that a request is sampled is still applied.
- State CLEAR:
  - 8 cycles; back-buffer row k is set to CLR_VAL in the k-th cycle.
  - After the 8th cycle: pulse clear_done for 1 cycle, then return to IDLE.
  - clear_done and the IDLE re-entry occur in the same cycle.
- State PEND:
  - Wait for a frame boundary; waits indefinitely if row_tick never arrives.
  - At the boundary edge, toggle front select. data shows the new frame from that edge, and scan_row becomes 0 at the same edge.
  - Go to ACK.
  - A boundary that coincides with the IDLE->PEND transition edge is not used; the swap happens one frame later.
- State ACK:
  - commit_ack=1 for one cycle, then go to IDLE (or COPY, see Optional Feature).
  - The requester must drop commit_req in the cycle it sees commit_ack; if it stays high, a new commit is started.
- data is a registered path from the buffer storage only. It never changes except at a swap edge or reset.
- Writes are never dropped silently: wr_ready=0 stalls the requester.

Optional Feature:
- Macro: MATRIX_SCHED_COPY_EN.
- Defined: after ACK the block enters COPY for 8 cycles, copying the new front buffer into the back buffer one row per cycle (wr_ready=0, busy=1), then returns to IDLE. Incremental edits therefore build on the displayed frame.
- Undefined: ACK goes directly to IDLE. The back buffer then holds the previously displayed frame (classic ping-pong).

Test Plan:
- Reset with rst high for 3 cycles -> data=0, scan_row=0, wr_ready=0 during reset, wr_ready=1 the first cycle after reset.
- Write (r=0,c=0,rg=01) and (r=7,c=7,rg=10); commit; issue 8 row_ticks -> data unchanged until the edge where scan_row wraps 7->0, then data[112]=1 and data[15]=1 with all other bits 0; commit_ack pulses exactly once, the next cycle.
- Request commit while scan_row==7 and row_tick arrive in the same cycle -> no swap at that boundary; swap at the next scan_row 7->0 wrap, 8 row_ticks later.
- Hold clear_req and commit_req together with CLR_VAL=2'b11 -> CLEAR for 8 cycles, then clear_done, then PEND; after the next boundary data is all ones.
- Assert rst during PEND -> data=0 and state IDLE; no commit_ack ever occurs for the aborted request.
- With MATRIX_SCHED_COPY_EN: commit frame A; write one pixel; commit again -> the displayed frame is A plus that pixel. Without the macro, the same sequence displays only that pixel (the back buffer held the old frame 0).

Source files
------------

// File: rtl/matrix_frame_sched.sv
// matrix_frame_sched: double-buffered pixel store feeding the 8x8 bicolour scan driver.
// Optional build macro MATRIX_SCHED_COPY_EN: refill back buffer from new front after each swap.
module matrix_frame_sched #(
    parameter logic [1:0] CLR_VAL = 2'b00
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         row_tick,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [2:0]   wr_row,
    input  logic [2:0]   wr_col,
    input  logic [1:0]   wr_rg,
    input  logic         clear_req,
    output logic         clear_done,
    input  logic         commit_req,
    output logic         commit_ack,
    output logic [2:0]   scan_row,
    output logic [127:0] data,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PEND,
        ACK,
        COPY
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           fsel_q, fsel_d;
    logic           done_q, done_d;
    logic [2:0]     scan_row_q, scan_row_d;
    logic [127:0]   data_q, data_d;
    logic [127:0]   buf0_q, buf0_d;
    logic [127:0]   buf1_q, buf1_d;

    logic [127:0]   front_w;
    logic [127:0]   back_w;
    logic [127:0]   back_d;
    logic [6:0]     wr_idx;
    logic [6:0]     row_base;
    logic           wr_fire;
    logic           boundary;

    // fsel_q picks which buffer is on display; the other one takes edits
    assign front_w  = fsel_q ? buf1_q : buf0_q;
    assign back_w   = fsel_q ? buf0_q : buf1_q;

    // row 0 sits in the top 16 bits of the driver word
    assign wr_idx   = {~wr_row, wr_col, 1'b0};
    assign row_base = {~cnt_q, 4'b0000};

    assign wr_ready   = (state_q == IDLE) && !rst;
    assign wr_fire    = wr_valid && wr_ready;
    assign boundary   = row_tick && (scan_row_q == 3'd7);
    assign commit_ack = (state_q == ACK);
    assign busy       = (state_q != IDLE);
    assign clear_done = done_q;
    assign scan_row   = scan_row_q;
    assign data       = data_q;

    // control FSM: clear / wait-for-boundary / ack / optional copy-back
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fsel_d  = fsel_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = 3'd0;
                end else if (commit_req) begin
                    state_d = PEND;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            PEND: begin
                if (boundary) begin
                    state_d = ACK;
                    fsel_d  = ~fsel_q;
                    data_d  = back_w;
                end
            end
            ACK: begin
`ifdef MATRIX_SCHED_COPY_EN
                state_d = COPY;
                cnt_d   = 3'd0;
`else
                state_d = IDLE;
`endif
            end
            COPY: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // back-buffer edits: pixel write, row clear or row copy; front is never touched
    always_comb begin
        back_d = back_w;
        case (state_q)
            IDLE: begin
                if (wr_fire) begin
                    back_d[wr_idx +: 2] = wr_rg;
                end
            end
            CLEAR:   back_d[row_base +: 16] = {8{CLR_VAL}};
            COPY:    back_d[row_base +: 16] = front_w[row_base +: 16];
            default: back_d = back_w;
        endcase
        buf0_d = fsel_q ? back_d : buf0_q;
        buf1_d = fsel_q ? buf1_q : back_d;
    end

    // scan row follows the driver in every state, wrapping 7 -> 0
    always_comb begin
        scan_row_d = scan_row_q;
        if (row_tick) begin
            scan_row_d = scan_row_q + 3'd1;
        end
    end

    // control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            fsel_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fsel_q  <= fsel_d;
            done_q  <= done_d;
        end
    end

    // pixel storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf0_q <= '0;
            buf1_q <= '0;
        end else begin
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
        end
    end

    // driver-facing registers: row counter and displayed frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_row_q <= 3'd0;
            data_q     <= '0;
        end else begin
            scan_row_q <= scan_row_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_matrix_frame_sched.sv
// tb_matrix_frame_sched: directed checks of write, commit timing, clear and reset abort.
// Expected frames depend on MATRIX_SCHED_COPY_EN.
module tb_matrix_frame_sched;

    logic         clk;
    logic         rst;
    logic         row_tick;
    logic         wr_valid;
    logic         wr_ready;
    logic [2:0]   wr_row;
    logic [2:0]   wr_col;
    logic [1:0]   wr_rg;
    logic         clear_req;
    logic         clear_done;
    logic         commit_req;
    logic         commit_ack;
    logic [2:0]   scan_row;
    logic [127:0] data;
    logic         busy;

    int n_chk;
    int n_fail;

    localparam logic [127:0] F1 = (128'd1 << 112) | (128'd1 << 15);
    localparam logic [127:0] PX = 128'd3 << 72;
    localparam logic [127:0] FA = 128'd1 << 100;
    localparam logic [127:0] PB = 128'd1 << 27;
`ifdef MATRIX_SCHED_COPY_EN
    localparam logic [127:0] F2 = F1 | PX;
    localparam logic [127:0] FB = FA | PB;
`else
    localparam logic [127:0] F2 = PX;
    localparam logic [127:0] FB = PB;
`endif
    localparam logic [127:0] ONES = {128{1'b1}};

    matrix_frame_sched #(.CLR_VAL(2'b11)) dut (
        .clk        (clk),
        .rst        (rst),
        .row_tick   (row_tick),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_rg      (wr_rg),
        .clear_req  (clear_req),
        .clear_done (clear_done),
        .commit_req (commit_req),
        .commit_ack (commit_ack),
        .scan_row   (scan_row),
        .data       (data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rowticks(input int n);
        for (int i = 0; i < n; i++) begin
            row_tick = 1'b1;
            tick();
            row_tick = 1'b0;
        end
    endtask

    task automatic write_px(input logic [2:0] r, input logic [2:0] c,
                            input logic [1:0] rg);
        wr_valid = 1'b1;
        wr_row   = r;
        wr_col   = c;
        wr_rg    = rg;
        check("wr_ready_write", 128'(wr_ready), 128'd1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!wr_ready && k < 30) begin
            tick();
            k++;
        end
        check("wait_idle", 128'(wr_ready), 128'd1);
    endtask

    // expects IDLE with scan_row==0 on entry
    task automatic commit_frame(input logic [127:0] old_f,
                                input logic [127:0] new_f);
        commit_req = 1'b1;
        tick();
        check("pend_busy", 128'(busy), 128'd1);
        check("pend_wr_ready", 128'(wr_ready), 128'd0);
        rowticks(7);
        check("pre_swap_scan", 128'(scan_row), 128'd7);
        check("pre_swap_data", data, old_f);
        check("pre_swap_ack", 128'(commit_ack), 128'd0);
        rowticks(1);
        check("swap_scan", 128'(scan_row), 128'd0);
        check("swap_data", data, new_f);
        check("swap_ack", 128'(commit_ack), 128'd1);
        commit_req = 1'b0;
        tick();
        check("ack_once", 128'(commit_ack), 128'd0);
`ifdef MATRIX_SCHED_COPY_EN
        check("copy_busy", 128'(busy), 128'd1);
        check("copy_wr_ready", 128'(wr_ready), 128'd0);
`endif
        wait_idle();
        check("post_commit_data", data, new_f);
    endtask

    initial begin
        int acks;
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        row_tick   = 1'b0;
        wr_valid   = 1'b0;
        wr_row     = 3'd0;
        wr_col     = 3'd0;
        wr_rg      = 2'd0;
        clear_req  = 1'b0;
        commit_req = 1'b0;

        // reset
        repeat (3) tick();
        check("rst_data", data, 128'd0);
        check("rst_scan", 128'(scan_row), 128'd0);
        check("rst_wr_ready", 128'(wr_ready), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ack", 128'(commit_ack), 128'd0);
        check("rst_done", 128'(clear_done), 128'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 128'(wr_ready), 128'd1);

        // two corner pixels, then commit
        write_px(3'd0, 3'd0, 2'b01);
        write_px(3'd7, 3'd7, 2'b10);
        check("no_early_data", data, 128'd0);
        commit_frame(128'd0, F1);

        // commit sampled on a boundary edge: that boundary is skipped
        write_px(3'd3, 3'd4, 2'b11);
        rowticks(7);
        check("coinc_scan7", 128'(scan_row), 128'd7);
        commit_req = 1'b1;
        row_tick   = 1'b1;
        tick();
        row_tick   = 1'b0;
        check("coinc_scan0", 128'(scan_row), 128'd0);
        check("coinc_busy", 128'(busy), 128'd1);
        check("coinc_no_swap", data, F1);
        check("coinc_no_ack", 128'(commit_ack), 128'd0);
        rowticks(7);
        check("coinc_hold", data, F1);
        check("coinc_hold_ack", 128'(commit_ack), 128'd0);
        rowticks(1);
        check("coinc_swap", data, F2);
        check("coinc_ack", 128'(commit_ack), 128'd1);
        commit_req = 1'b0;
        tick();
        check("coinc_ack_once", 128'(commit_ack), 128'd0);
        wait_idle();

        // clear and commit together: clear first, then commit
        clear_req  = 1'b1;
        commit_req = 1'b1;
        tick();
        check("clr_busy", 128'(busy), 128'd1);
        check("clr_wr_ready", 128'(wr_ready), 128'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("clr_no_done", 128'(clear_done), 128'd0);
        end
        tick();
        check("clr_done", 128'(clear_done), 128'd1);
        check("clr_idle", 128'(busy), 128'd0);
        clear_req = 1'b0;
        tick();
        check("clr_done_once", 128'(clear_done), 128'd0);
        check("clr_then_pend", 128'(busy), 128'd1);
        rowticks(7);
        check("clr_pre_swap", data, F2);
        rowticks(1);
        check("clr_swap_data", data, ONES);
        check("clr_swap_ack", 128'(commit_ack), 128'd1);
        commit_req = 1'b0;
        tick();
        wait_idle();

        // reset while waiting for the boundary
        commit_req = 1'b1;
        tick();
        rowticks(3);
        check("abort_pend", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        check("abort_data", data, 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_scan", 128'(scan_row), 128'd0);
        check("abort_wr_ready", 128'(wr_ready), 128'd0);
        commit_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("abort_ready", 128'(wr_ready), 128'd1);
        acks = 0;
        for (int i = 0; i < 16; i++) begin
            rowticks(1);
            if (commit_ack) acks++;
        end
        check("abort_no_ack", 128'(acks), 128'd0);
        check("abort_data_hold", data, 128'd0);
        check("abort_idle", 128'(busy), 128'd0);

        // frame A, one more pixel, commit again
        write_px(3'd1, 3'd2, 2'b01);
        commit_frame(128'd0, FA);
        write_px(3'd6, 3'd5, 2'b10);
        commit_frame(FA, FB);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
